// File: rtl/con_pkg.sv
// Shared definitions for the branch-condition unit: condition modes, condition
// codes and FSM state encoding.
package con_pkg;

  localparam logic CON_MODE_ZERO = 1'b0;
  localparam logic CON_MODE_CMP  = 1'b1;

  // Mode 0: tests on the B operand alone
  localparam logic [2:0] CODE_ZR     = 3'b000;
  localparam logic [2:0] CODE_NZ     = 3'b001;
  localparam logic [2:0] CODE_PL     = 3'b010;
  localparam logic [2:0] CODE_MI     = 3'b011;
  localparam logic [2:0] CODE_ALWAYS = 3'b100;
  localparam logic [2:0] CODE_NEVER  = 3'b101;
  localparam logic [2:0] CODE_NONNEG = 3'b110;
  localparam logic [2:0] CODE_NONPOS = 3'b111;

  // Mode 1: A versus B comparisons
  localparam logic [2:0] CODE_EQ  = 3'b000;
  localparam logic [2:0] CODE_NE  = 3'b001;
  localparam logic [2:0] CODE_LT  = 3'b010;
  localparam logic [2:0] CODE_GE  = 3'b011;
  localparam logic [2:0] CODE_LTU = 3'b100;
  localparam logic [2:0] CODE_GEU = 3'b101;
  localparam logic [2:0] CODE_GT  = 3'b110;
  localparam logic [2:0] CODE_LE  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } con_state_t;

endpackage

// File: rtl/con_eval.sv
// Combinational condition evaluator: zero/sign tests on B, or signed/unsigned
// comparisons of A against B, selected by cond.
module con_eval
  import con_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             result
);

  logic b_zero;
  logic b_neg;

  assign b_zero = (b == '0);
  assign b_neg  = b[WIDTH-1];

  always_comb begin
    result = 1'b0;
    if (cond[3] == CON_MODE_ZERO) begin
      case (cond[2:0])
        CODE_ZR:     result = b_zero;
        CODE_NZ:     result = !b_zero;
        CODE_PL:     result = !b_neg && !b_zero;
        CODE_MI:     result = b_neg;
        CODE_ALWAYS: result = 1'b1;
        CODE_NEVER:  result = 1'b0;
        CODE_NONNEG: result = !b_neg;
        CODE_NONPOS: result = b_neg || b_zero;
        default:     result = 1'b0;
      endcase
    end else begin
      case (cond[2:0])
        CODE_EQ:  result = (a == b);
        CODE_NE:  result = (a != b);
        CODE_LT:  result = ($signed(a) <  $signed(b));
        CODE_GE:  result = ($signed(a) >= $signed(b));
        CODE_LTU: result = (a <  b);
        CODE_GEU: result = (a >= b);
        CODE_GT:  result = ($signed(a) >  $signed(b));
        CODE_LE:  result = ($signed(a) <= $signed(b));
        default:  result = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch-condition unit: snapshots operands on request, evaluates one cycle
// later and holds the latched result until the sequencer acknowledges it.
module branch_cond_unit
  import con_pkg::*;
#(
  parameter int   WIDTH    = 32,
  parameter logic INIT_VAL = 1'b0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [3:0]       cond,
  input  logic             load_a,
  input  logic             con_in,
  input  logic             ack,
  output logic             con_out,
  output logic             con_valid,
  output logic             busy,
  output logic             con_drop,
  output logic             flag_z,
  output logic             flag_n
);

  con_state_t       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] a_snap;
  logic [WIDTH-1:0] b_snap;
  logic [3:0]       cond_snap;
  logic             eval_result;

  con_eval #(.WIDTH(WIDTH)) u_eval (
    .cond   (cond_snap),
    .a      (a_snap),
    .b      (b_snap),
    .result (eval_result)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      con_out   <= INIT_VAL;
      con_valid <= 1'b0;
      con_drop  <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      a_reg     <= '0;
      a_snap    <= '0;
      b_snap    <= '0;
      cond_snap <= '0;
    end else begin
      con_drop <= 1'b0;
      if (load_a) a_reg <= bus_in;

      case (state)
        ST_IDLE: begin
          // a_snap takes the pre-update A even when load_a fires this cycle
          if (con_in) begin
            b_snap    <= bus_in;
            a_snap    <= a_reg;
            cond_snap <= cond;
            state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          con_out   <= eval_result;
          flag_z    <= (b_snap == '0);
          flag_n    <= b_snap[WIDTH-1];
          con_valid <= 1'b1;
          state     <= ST_HOLD;
          if (con_in) con_drop <= 1'b1;
        end
        ST_HOLD: begin
          if (ack) begin
            con_valid <= 1'b0;
            if (con_in) begin
              b_snap    <= bus_in;
              a_snap    <= a_reg;
              cond_snap <= cond;
              state     <= ST_EVAL;
            end else begin
              state <= ST_IDLE;
            end
          end else if (con_in) begin
            con_drop <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed and randomized checks of branch_cond_unit against an arithmetic
// reference model, on a 32-bit and an 8-bit instance.
module tb_branch_cond_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] bus_in = '0;
  logic [3:0]  cond = '0;
  logic        load_a = 1'b0, con_in = 1'b0, ack = 1'b0;
  logic        con_out, con_valid, busy, con_drop, flag_z, flag_n;

  logic [7:0]  bus8 = '0;
  logic [3:0]  cond8 = '0;
  logic        load_a8 = 1'b0, con_in8 = 1'b0, ack8 = 1'b0;
  logic        con_out8, con_valid8, busy8, con_drop8, flag_z8, flag_n8;

  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  branch_cond_unit #(.WIDTH(32)) dut (
    .clock(clock), .resetn(resetn), .bus_in(bus_in), .cond(cond),
    .load_a(load_a), .con_in(con_in), .ack(ack),
    .con_out(con_out), .con_valid(con_valid), .busy(busy),
    .con_drop(con_drop), .flag_z(flag_z), .flag_n(flag_n)
  );

  branch_cond_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .resetn(resetn), .bus_in(bus8), .cond(cond8),
    .load_a(load_a8), .con_in(con_in8), .ack(ack8),
    .con_out(con_out8), .con_valid(con_valid8), .busy(busy8),
    .con_drop(con_drop8), .flag_z(flag_z8), .flag_n(flag_n8)
  );

  // Reference: interpret operands as integers of width w and apply the rule table.
  function automatic logic model(input logic [3:0] c, input longint a, input longint b, input int w);
    longint lim, sa, sb;
    lim = longint'(1) << w;
    sa = (a >= lim / 2) ? a - lim : a;
    sb = (b >= lim / 2) ? b - lim : b;
    if (!c[3]) begin
      case (c[2:0])
        3'd0: return sb == 0;
        3'd1: return sb != 0;
        3'd2: return sb > 0;
        3'd3: return sb < 0;
        3'd4: return 1'b1;
        3'd5: return 1'b0;
        3'd6: return sb >= 0;
        default: return sb <= 0;
      endcase
    end else begin
      case (c[2:0])
        3'd0: return sa == sb;
        3'd1: return sa != sb;
        3'd2: return sa < sb;
        3'd3: return sa >= sb;
        3'd4: return a < b;
        3'd5: return a >= b;
        3'd6: return sa > sb;
        default: return sa <= sb;
      endcase
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load32(input logic [31:0] v);
    load_a = 1'b1; bus_in = v;
    step();
    load_a = 1'b0;
  endtask

  // Issue a request from IDLE; returns with the result visible.
  task automatic request32(input logic [3:0] c, input logic [31:0] b);
    con_in = 1'b1; cond = c; bus_in = b;
    step();
    con_in = 1'b0;
    step();
  endtask

  task automatic consume32();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  logic [31:0] pool [6];
  logic [31:0] ra, rb;
  logic [3:0]  rc;
  logic [7:0]  bvals [5];
  logic [7:0]  avals [3];
  logic        e;

  initial begin
    // Reset state
    step(); step();
    chk("rst_con_out", con_out, 1'b0);
    chk("rst_con_valid", con_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_con_drop", con_drop, 1'b0);
    chk("rst_flags", {flag_z, flag_n}, 2'b00);
    resetn = 1'b1;
    step();

    // 1: zero test, hold, ack
    request32(4'b0000, 32'h0);
    chk("t1_valid", con_valid, 1'b1);
    chk("t1_out", con_out, 1'b1);
    chk("t1_flag_z", flag_z, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_hold_valid", con_valid, 1'b1);
    end
    consume32();
    chk("t1_ack_valid", con_valid, 1'b0);
    chk("t1_ack_out", con_out, 1'b1);
    chk("t1_idle", busy, 1'b0);

    // 2: signed vs unsigned less-than with A=-1, B=1
    load32(32'hFFFF_FFFF);
    request32(4'b1010, 32'h1);
    chk("t2_lt", con_out, 1'b1);
    chk("t2_flag_n", flag_n, 1'b0);
    consume32();
    request32(4'b1100, 32'h1);
    chk("t2_ltu", con_out, 1'b0);
    consume32();

    // 3: con_in uses A from before a same-cycle load_a
    load32(32'd5);
    load_a = 1'b1; con_in = 1'b1; cond = 4'b1000; bus_in = 32'd9;
    step();
    load_a = 1'b0; con_in = 1'b0;
    step();
    chk("t3_old_a_eq", con_out, 1'b0);
    consume32();
    request32(4'b1000, 32'd9);
    chk("t3_new_a_eq", con_out, 1'b1);
    consume32();
    request32(4'b1000, 32'd7);
    chk("t3_ne_eq", con_out, 1'b0);
    consume32();

    // 4: drops in EVAL and in HOLD, then back-to-back ack+con_in
    con_in = 1'b1; cond = 4'b0001; bus_in = 32'h0;
    step();
    step();
    con_in = 1'b0;
    chk("t4_eval_drop", con_drop, 1'b1);
    chk("t4_nz_out", con_out, 1'b0);
    step();
    chk("t4_drop_clear", con_drop, 1'b0);
    con_in = 1'b1; cond = 4'b0100;
    step();
    con_in = 1'b0;
    chk("t4_hold_drop", con_drop, 1'b1);
    chk("t4_hold_out", con_out, 1'b0);
    chk("t4_hold_valid", con_valid, 1'b1);
    step();
    chk("t4_drop_pulse", con_drop, 1'b0);
    ack = 1'b1; con_in = 1'b1; cond = 4'b0100;
    step();
    ack = 1'b0; con_in = 1'b0;
    chk("t4_b2b_valid", con_valid, 1'b0);
    chk("t4_b2b_busy", busy, 1'b1);
    step();
    chk("t4_b2b_out", con_out, 1'b1);
    chk("t4_b2b_valid2", con_valid, 1'b1);
    consume32();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t4_ack_idle_ignored", busy, 1'b0);

    // 5: asynchronous reset during EVAL
    con_in = 1'b1; cond = 4'b0101; bus_in = 32'h80;
    step();
    con_in = 1'b0;
    #1 resetn = 1'b0;
    #1;
    chk("t5_valid", con_valid, 1'b0);
    chk("t5_out", con_out, 1'b0);
    chk("t5_busy", busy, 1'b0);
    #1 resetn = 1'b1;
    step();
    chk("t5_stays_idle", busy, 1'b0);

    // 6: WIDTH=8 sweep
    bvals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    avals = '{8'h80, 8'h00, 8'h7F};
    foreach (avals[ia]) begin
      load_a8 = 1'b1; bus8 = avals[ia];
      step();
      load_a8 = 1'b0;
      foreach (bvals[ib]) begin
        for (int c = 0; c < 16; c++) begin
          con_in8 = 1'b1; cond8 = 4'(c); bus8 = bvals[ib];
          step();
          con_in8 = 1'b0;
          step();
          e = model(4'(c), longint'(avals[ia]), longint'(bvals[ib]), 8);
          chk($sformatf("w8 c=%0h a=%0h b=%0h", c, avals[ia], bvals[ib]), con_out8, e);
          ack8 = 1'b1;
          step();
          ack8 = 1'b0;
        end
      end
    end

    // Randomized 32-bit transactions with corner-biased operands
    pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0};
    for (int n = 0; n < 200; n++) begin
      pool[5] = $urandom;
      ra = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      rc = 4'($urandom_range(0, 15));
      load32(ra);
      request32(rc, rb);
      e = model(rc, longint'(ra), longint'(rb), 32);
      chk($sformatf("rnd c=%0h a=%0h b=%0h", rc, ra, rb), con_out, e);
      chk("rnd_flag_z", flag_z, rb == 0);
      chk("rnd_flag_n", flag_n, rb[31]);
      consume32();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
